rx_frame_parser: RTL

Receive-side frame parser that sits directly downstream of the word aligner. It consumes aligned 32-bit words and hunts for the sync word 32'h0000F731, then validates a length header. It forwards payload words with a last-word marker and checks an optional additive checksum. It reports per-frame OK/error pulses, a saturating error count and a link-lock status.

---
 rtl/rx_frame_parser.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/rx_frame_parser.sv
// rx_frame_parser: hunts for the sync word on the aligned word stream, validates
// the length header, forwards payload words with a last-word marker and reports
// per-frame OK/error pulses, a saturating error count and link lock.
// Optional feature macro: RX_FRAME_CSUM_EN (trailing additive checksum word).
module rx_frame_parser #(
    parameter int unsigned MAX_LEN   = 256,
    parameter int unsigned ERR_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RSTX,
    input  logic        PHY_INIT,
    input  logic        ALIGNED,
    input  logic        DIPUSH,
    input  logic [31:0] DIN,
    output logic        DOPUSH,
    output logic [31:0] DOUT,
    output logic        DOLAST,
    output logic        FRM_OK,
    output logic        FRM_ERR,
    output logic [15:0] ERR_CNT,
    output logic        LOCKED
);

    localparam int unsigned DW = 32;
    localparam int unsigned LW = 16;
    localparam int unsigned CW = 4;

    localparam logic [DW-1:0] SYNC_WORD = 32'h0000F731;
    localparam logic [LW-1:0] MAX_N     = LW'(MAX_LEN);
    localparam logic [CW-1:0] ERR_LIM   = CW'(ERR_LIMIT);
    localparam logic [LW-1:0] CNT_SAT   = 16'hFFFF;
    localparam logic [CW-1:0] CONS_SAT  = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HUNT,
        ST_HDR,
        ST_PAY,
        ST_CSUM
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] cnt_q, cnt_d;
`ifdef RX_FRAME_CSUM_EN
    logic [DW-1:0] sum_q, sum_d;
`endif
    logic          dopush_d, dolast_d, ok_d, err_d;
    logic [DW-1:0] dout_d;
    logic [CW-1:0] consec_q, consec_d;
    logic [LW-1:0] err_cnt_d;
    logic          locked_d;
    logic [LW-1:0] hdr_n;
    logic          hdr_ok;
    logic          in_frame;

    // Header is valid when the upper half is the complement of a legal length.
    assign hdr_n    = DIN[15:0];
    assign hdr_ok   = (DIN[31:16] == ~DIN[15:0]) && (hdr_n != '0) && (hdr_n <= MAX_N);
    assign in_frame = (state_q == ST_HDR) || (state_q == ST_PAY) || (state_q == ST_CSUM);

    // State register and per-frame working registers.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
`ifdef RX_FRAME_CSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef RX_FRAME_CSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Next state and next registered outputs; PHY_INIT beats alignment loss beats data.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
`ifdef RX_FRAME_CSUM_EN
        sum_d    = sum_q;
`endif
        dopush_d = 1'b0;
        dolast_d = 1'b0;
        dout_d   = DOUT;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        if (PHY_INIT) begin
            state_d = ST_IDLE;
        end else if (!ALIGNED) begin
            state_d = ST_IDLE;
            err_d   = in_frame;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_HUNT;
                ST_HUNT: begin
                    if (DIPUSH && (DIN == SYNC_WORD)) begin
                        state_d = ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (DIPUSH) begin
                        if (hdr_ok) begin
                            cnt_d   = hdr_n;
`ifdef RX_FRAME_CSUM_EN
                            sum_d   = '0;
`endif
                            state_d = ST_PAY;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_HUNT;
                        end
                    end
                end
                ST_PAY: begin
                    if (DIPUSH) begin
                        dopush_d = 1'b1;
                        dout_d   = DIN;
                        cnt_d    = cnt_q - 16'd1;
`ifdef RX_FRAME_CSUM_EN
                        sum_d    = sum_q + DIN;
`endif
                        if (cnt_q == 16'd1) begin
                            dolast_d = 1'b1;
`ifdef RX_FRAME_CSUM_EN
                            state_d  = ST_CSUM;
`else
                            ok_d     = 1'b1;
                            state_d  = ST_HUNT;
`endif
                        end
                    end
                end
`ifdef RX_FRAME_CSUM_EN
                ST_CSUM: begin
                    if (DIPUSH) begin
                        ok_d    = (DIN == sum_q);
                        err_d   = (DIN != sum_q);
                        state_d = ST_HUNT;
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Error count, consecutive-error tracking and lock, aligned with the frame pulses.
    always_comb begin
        err_cnt_d = ERR_CNT;
        consec_d  = consec_q;
        locked_d  = LOCKED;
        if (PHY_INIT) begin
            consec_d = '0;
            locked_d = 1'b0;
        end else if (ok_d) begin
            consec_d = '0;
            locked_d = 1'b1;
        end else if (err_d) begin
            if (ERR_CNT != CNT_SAT) begin
                err_cnt_d = ERR_CNT + 16'd1;
            end
            if (consec_q != CONS_SAT) begin
                consec_d = consec_q + 4'd1;
            end
            if (consec_d >= ERR_LIM) begin
                locked_d = 1'b0;
            end
        end
    end

    // Output and status registers.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            DOPUSH   <= 1'b0;
            DOUT     <= '0;
            DOLAST   <= 1'b0;
            FRM_OK   <= 1'b0;
            FRM_ERR  <= 1'b0;
            ERR_CNT  <= '0;
            LOCKED   <= 1'b0;
            consec_q <= '0;
        end else begin
            DOPUSH   <= dopush_d;
            DOUT     <= dout_d;
            DOLAST   <= dolast_d;
            FRM_OK   <= ok_d;
            FRM_ERR  <= err_d;
            ERR_CNT  <= err_cnt_d;
            LOCKED   <= locked_d;
            consec_q <= consec_d;
        end
    end

endmodule
